conv1d_multi: RTL and testbench



---
 rtl/conv1d_multi.sv | 146 ++++++++++++++
 tb/tb_conv1d_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_multi.sv
// rtl/conv1d_multi.sv - streaming 1-D convolution, one output channel, time-multiplexed MACs
module conv1d_multi #(
    parameter int DATA_WIDTH  = 12,
    parameter int FILTER_SIZE = 5,
    parameter int NUM_MULT    = 1,
    parameter int STRIDE      = 1,
    parameter int PAD_MODE    = 0,
    parameter int FRAC_BITS   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    output logic                                  conv1d_ready_in,
    input  logic                                  conv1d_valid_in,
    input  logic [DATA_WIDTH-1:0]                 conv1d_data_in,
    input  logic                                  conv1d_last_in,
    input  logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] conv1d_weights,
    input  logic [DATA_WIDTH-1:0]                 conv1d_bias,
    input  logic                                  conv1d_relu_en,
    input  logic                                  conv1d_ready_out,
    output logic                                  conv1d_valid_out,
    output logic [DATA_WIDTH-1:0]                 conv1d_data_out,
    output logic                                  conv1d_last_out
);

    localparam int NUM_STEPS = (FILTER_SIZE + NUM_MULT - 1) / NUM_MULT;
    localparam int PROD_W    = 2 * DATA_WIDTH;
    localparam int ACC_W     = 2 * DATA_WIDTH + $clog2(FILTER_SIZE) + 1;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int CNT_W     = $clog2(FILTER_SIZE + 1);
    localparam int PH_W      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;
    state_t state, state_next;

    logic signed [DATA_WIDTH-1:0] window [FILTER_SIZE];
    logic [CNT_W-1:0]             sample_cnt;
    logic [PH_W-1:0]              stride_ph;
    logic [STEP_W-1:0]            step;
    logic signed [ACC_W-1:0]      acc;
    logic                         last_pend;

    logic accept, eligible, need_out, last_step, out_free;
    logic signed [DATA_WIDTH-1:0] op_a [NUM_MULT];
    logic signed [DATA_WIDTH-1:0] op_w [NUM_MULT];
    logic signed [PROD_W-1:0]     prod [NUM_MULT];
    logic signed [ACC_W-1:0]      step_sum, shifted, biased;
    logic signed [DATA_WIDTH-1:0] result;

    assign conv1d_ready_in = (state == IDLE);
    assign accept    = conv1d_valid_in & conv1d_ready_in;
    assign eligible  = (PAD_MODE == 0) || (sample_cnt >= CNT_W'(FILTER_SIZE - 1));
    assign need_out  = conv1d_last_in | (eligible & (stride_ph == '0));
    assign last_step = (step == STEP_W'(NUM_STEPS - 1));
    assign out_free  = ~conv1d_valid_out | conv1d_ready_out;

    // Operand muxes pick this step's taps; taps past the end of the kernel read as zero.
    always_comb begin
        step_sum = '0;
        for (int j = 0; j < NUM_MULT; j++) begin
            op_a[j] = '0;
            op_w[j] = '0;
            for (int k = 0; k < FILTER_SIZE; k++) begin
                if (int'(step) * NUM_MULT + j == k) begin
                    op_a[j] = window[k];
                    op_w[j] = $signed(conv1d_weights[k]);
                end
            end
            prod[j]  = PROD_W'(op_a[j]) * PROD_W'(op_w[j]);
            step_sum = step_sum + ACC_W'(prod[j]);
        end
    end

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        biased  = shifted + ACC_W'($signed(conv1d_bias));
        if (biased > SAT_MAX)
            result = SAT_MAX[DATA_WIDTH-1:0];
        else if (biased < SAT_MIN)
            result = SAT_MIN[DATA_WIDTH-1:0];
        else
            result = biased[DATA_WIDTH-1:0];
        if (conv1d_relu_en && result[DATA_WIDTH-1])
            result = '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && need_out) state_next = COMPUTE;
            COMPUTE: if (last_step) state_next = FINISH;
            FINISH:  if (out_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            for (int k = 0; k < FILTER_SIZE; k++) window[k] <= '0;
            sample_cnt       <= '0;
            stride_ph        <= '0;
            step             <= '0;
            acc              <= '0;
            last_pend        <= 1'b0;
            conv1d_valid_out <= 1'b0;
            conv1d_data_out  <= '0;
            conv1d_last_out  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (accept) begin
                    for (int k = FILTER_SIZE - 1; k > 0; k--) window[k] <= window[k-1];
                    window[0] <= conv1d_data_in;
                    if (sample_cnt != CNT_W'(FILTER_SIZE)) sample_cnt <= sample_cnt + CNT_W'(1);
                    if (eligible)
                        stride_ph <= (stride_ph == PH_W'(STRIDE - 1)) ? '0 : stride_ph + PH_W'(1);
                    step      <= '0;
                    acc       <= '0;
                    last_pend <= conv1d_last_in;
                end
                COMPUTE: begin
                    acc  <= acc + step_sum;
                    step <= step + STEP_W'(1);
                    // Operands are consumed by the last step, so a frame end can wipe history now.
                    if (last_step && last_pend) begin
                        for (int k = 0; k < FILTER_SIZE; k++) window[k] <= '0;
                        sample_cnt <= '0;
                        stride_ph  <= '0;
                    end
                end
                default: ;
            endcase

            if (state == FINISH && out_free) begin
                conv1d_valid_out <= 1'b1;
                conv1d_data_out  <= result;
                conv1d_last_out  <= last_pend;
            end else if (conv1d_ready_out) begin
                conv1d_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_multi.sv
// tb/tb_conv1d_multi.sv - random and directed scoreboard bench for two conv1d_multi configurations
module tb_conv1d_multi;

    localparam int F = 3;
    localparam int M_P[2]   = '{1, 2};
    localparam int S_P[2]   = '{1, 2};
    localparam int PAD_P[2] = '{0, 1};
    localparam int FR_P[2]  = '{0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic             vi [2];
    logic [7:0]       di [2];
    logic             li [2];
    logic [2:0][7:0]  wv [2];
    logic [7:0]       bv [2];
    logic             re [2];
    logic             ro [2];
    logic             ri [2];
    logic             vo [2];
    logic [7:0]       dout [2];
    logic             lo [2];

    int n_pass = 0;
    int n_checks = 0;

    int win [2][F];
    int nsamp [2];
    int ecnt [2];
    int wt [2][F];
    int bias_m [2];
    bit relu_m [2];
    int exp_d [2][1024];
    bit exp_l [2][1024];
    int wr [2];
    int rd [2];
    int got_d [2][1024];
    bit got_l [2][1024];
    int got_n [2];
    int rdy_mode [2];
    bit hold [2];
    int hold_d [2];
    bit hold_l [2];

    conv1d_multi #(.DATA_WIDTH(8), .FILTER_SIZE(F), .NUM_MULT(M_P[0]), .STRIDE(S_P[0]),
                   .PAD_MODE(PAD_P[0]), .FRAC_BITS(FR_P[0])) dut0 (
        .clk(clk), .rst(rst), .conv1d_ready_in(ri[0]), .conv1d_valid_in(vi[0]),
        .conv1d_data_in(di[0]), .conv1d_last_in(li[0]), .conv1d_weights(wv[0]),
        .conv1d_bias(bv[0]), .conv1d_relu_en(re[0]), .conv1d_ready_out(ro[0]),
        .conv1d_valid_out(vo[0]), .conv1d_data_out(dout[0]), .conv1d_last_out(lo[0]));

    conv1d_multi #(.DATA_WIDTH(8), .FILTER_SIZE(F), .NUM_MULT(M_P[1]), .STRIDE(S_P[1]),
                   .PAD_MODE(PAD_P[1]), .FRAC_BITS(FR_P[1])) dut1 (
        .clk(clk), .rst(rst), .conv1d_ready_in(ri[1]), .conv1d_valid_in(vi[1]),
        .conv1d_data_in(di[1]), .conv1d_last_in(li[1]), .conv1d_weights(wv[1]),
        .conv1d_bias(bv[1]), .conv1d_relu_en(re[1]), .conv1d_ready_out(ro[1]),
        .conv1d_valid_out(vo[1]), .conv1d_data_out(dout[1]), .conv1d_last_out(lo[1]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int num_steps(input int idx);
        return (F + M_P[idx] - 1) / M_P[idx];
    endfunction

    // Reference: dot product of the last F frame samples, newest against tap 0.
    function automatic void model_accept(input int idx, input int d, input bit last);
        longint acc, r;
        bit elig, emit;
        for (int k = F - 1; k > 0; k--) win[idx][k] = win[idx][k-1];
        win[idx][0] = d;
        nsamp[idx]++;
        elig = (PAD_P[idx] == 0) || (nsamp[idx] >= F);
        emit = last;
        if (elig) begin
            if (ecnt[idx] % S_P[idx] == 0) emit = 1'b1;
            ecnt[idx]++;
        end
        if (emit) begin
            acc = 0;
            for (int k = 0; k < F; k++) acc += longint'(win[idx][k]) * longint'(wt[idx][k]);
            r = (acc >>> FR_P[idx]) + longint'(bias_m[idx]);
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            if (relu_m[idx] && r < 0) r = 0;
            exp_d[idx][wr[idx] % 1024] = int'(r);
            exp_l[idx][wr[idx] % 1024] = last;
            wr[idx]++;
        end
        if (last) begin
            for (int k = 0; k < F; k++) win[idx][k] = 0;
            nsamp[idx] = 0;
            ecnt[idx] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < F; k++) win[i][k] = 0;
            nsamp[i] = 0;
            ecnt[i] = 0;
        end
    endfunction

    task automatic apply_cfg(input int idx, input int w0, input int w1, input int w2,
                             input int b, input bit relu);
        wt[idx][0] = w0; wt[idx][1] = w1; wt[idx][2] = w2;
        bias_m[idx] = b; relu_m[idx] = relu;
        for (int k = 0; k < F; k++) wv[idx][k] = 8'(wt[idx][k]);
        bv[idx] = 8'(b);
        re[idx] = relu;
    endtask

    task automatic send(input int idx, input int d, input bit last, input bit use_model);
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            vi[idx] = 1'b1; di[idx] = 8'(d); li[idx] = last;
            if (ri[idx]) begin
                if (use_model) model_accept(idx, d, last);
                @(posedge clk);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        #1 vi[idx] = 1'b0;
    endtask

    task automatic send_lat(input int idx, input int d, input bit last);
        int cyc = 0;
        bit seen = 1'b0;
        send(idx, d, last, 1'b1);
        while (cyc < 20 && !seen) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (vo[idx]) seen = 1'b1;
        end
        check("latency", cyc, num_steps(idx) + 1);
    endtask

    task automatic drain(input int idx);
        int t = 0;
        while ((rd[idx] != wr[idx] || vo[idx] || !ri[idx]) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 0, 1);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        always @(negedge clk) begin
            if (rst) begin
                hold[g] = 1'b0;
                ro[g] = 1'b0;
            end else begin
                if (hold[g]) begin
                    check("hold_valid", vo[g], 1);
                    check("hold_data", $signed(dout[g]), hold_d[g]);
                    check("hold_last", lo[g], hold_l[g]);
                end
                ro[g] = (rdy_mode[g] == 1) ? 1'b1 :
                        (rdy_mode[g] == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
                hold[g] = 1'b0;
                if (vo[g]) begin
                    if (ro[g]) begin
                        if (rd[g] == wr[g]) begin
                            check("spurious_out", vo[g], 0);
                        end else begin
                            check("out_data", $signed(dout[g]), exp_d[g][rd[g] % 1024]);
                            check("out_last", lo[g], exp_l[g][rd[g] % 1024]);
                            rd[g]++;
                        end
                        got_d[g][got_n[g] % 1024] = $signed(dout[g]);
                        got_l[g][got_n[g] % 1024] = lo[g];
                        got_n[g]++;
                    end else begin
                        hold[g] = 1'b1;
                        hold_d[g] = $signed(dout[g]);
                        hold_l[g] = lo[g];
                    end
                end
            end
        end
    end

    initial begin
        int base, d;
        for (int i = 0; i < 2; i++) begin
            vi[i] = 1'b0; di[i] = '0; li[i] = 1'b0;
            wr[i] = 0; rd[i] = 0; got_n[i] = 0; rdy_mode[i] = 1;
            apply_cfg(i, 1, 2, 3, 0, 1'b0);
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready_in", ri[i], 1);
            check("rst_valid_out", vo[i], 0);
            check("rst_data_out", dout[i], 0);
            check("rst_last_out", lo[i], 0);
        end
        rst = 1'b0;

        // Causal values and latency: weights [1,2,3], data 1..4
        base = got_n[0];
        send_lat(0, 1, 1'b0);
        send(0, 2, 1'b0, 1'b1);
        send(0, 3, 1'b0, 1'b1);
        send(0, 4, 1'b1, 1'b1);
        drain(0);
        check("causal_count", got_n[0] - base, 4);
        check("causal_0", got_d[0][base], 1);
        check("causal_1", got_d[0][base+1], 4);
        check("causal_2", got_d[0][base+2], 10);
        check("causal_3", got_d[0][base+3], 16);
        check("causal_last", got_l[0][base+3], 1);

        // Saturation and ReLU
        apply_cfg(0, 127, 127, 127, 0, 1'b0);
        for (int i = 0; i < 3; i++) send(0, 127, i == 2, 1'b1);
        drain(0);
        check("sat_pos", got_d[0][(got_n[0] - 1) % 1024], 127);
        apply_cfg(0, -128, -128, -128, 0, 1'b0);
        send(0, 127, 1'b1, 1'b1);
        drain(0);
        check("sat_neg", got_d[0][(got_n[0] - 1) % 1024], -128);
        apply_cfg(0, -128, -128, -128, 0, 1'b1);
        send(0, 127, 1'b1, 1'b1);
        drain(0);
        check("relu_zero", got_d[0][(got_n[0] - 1) % 1024], 0);

        // Valid mode, stride 2, two multipliers, one fractional bit: weights [2,4,6]
        apply_cfg(1, 2, 4, 6, 0, 1'b0);
        base = got_n[1];
        send(1, 1, 1'b0, 1'b1); @(negedge clk); check("skip_ready_1", ri[1], 1);
        send(1, 2, 1'b0, 1'b1); @(negedge clk); check("skip_ready_2", ri[1], 1);
        send_lat(1, 3, 1'b0);
        drain(1);
        send(1, 4, 1'b0, 1'b1); @(negedge clk); check("skip_ready_4", ri[1], 1);
        send(1, 5, 1'b1, 1'b1);
        drain(1);
        check("valid_count", got_n[1] - base, 2);
        check("valid_0", got_d[1][base], 10);
        check("valid_1", got_d[1][base+1], 22);
        check("valid_1_last", got_l[1][base+1], 1);

        // Backpressure: first result held, second parked in FINISH
        apply_cfg(0, 1, 2, 3, 0, 1'b0);
        rdy_mode[0] = 2;
        base = got_n[0];
        send(0, 1, 1'b1, 1'b1);
        for (int t = 0; t < 20 && !vo[0]; t++) @(negedge clk);
        send(0, 2, 1'b1, 1'b1);
        repeat (num_steps(0) + 1) @(negedge clk);
        check("bp_ready_in", ri[0], 0);
        check("bp_valid", vo[0], 1);
        check("bp_data", $signed(dout[0]), 1);
        repeat (6) @(negedge clk);
        rdy_mode[0] = 1;
        drain(0);
        check("bp_count", got_n[0] - base, 2);
        check("bp_first", got_d[0][base], 1);
        check("bp_second", got_d[0][base+1], 2);

        // Reset in the middle of a computation
        base = got_n[0];
        send(0, 50, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", vo[0], 0);
        check("midrst_data", dout[0], 0);
        rst = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        check("midrst_no_out", got_n[0] - base, 0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 2; i++) begin
            apply_cfg(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      1'($urandom_range(0, 1)));
            rdy_mode[i] = 0;
            for (int n = 0; n < 150; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                d = int'($urandom_range(0, 255)) - 128;
                send(i, d, $urandom_range(0, 7) == 0, 1'b1);
                if (n == 75) begin
                    drain(i);
                    apply_cfg(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                              1'($urandom_range(0, 1)));
                end
            end
            drain(i);
            rdy_mode[i] = 1;
            check("leftover", wr[i] - rd[i], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
